// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO state.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division. Each
// takes width+1 cycles. MTHI and MTLO write HI or LO directly and take one edge.
module muldiv_unit #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             flush,
    output logic [width-1:0] hi,
    output logic [width-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(width);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [width-1:0]     hi_q, lo_q;
    logic                 busy_q, done_q;
    logic                 is_div_q;
    logic                 neg_q;      // product/quotient sign
    logic                 rneg_q;     // remainder sign
    logic [width-1:0]     a_raw_q;    // raw dividend, returned in HI on divide by zero
    logic [width-1:0]     opnd_q;     // multiplicand (mul) or divisor (div), magnitude
    logic [2*width-1:0]   acc_q;      // mul: {partial, multiplier}; div: low half is quotient
    logic [width-1:0]     rem_q;      // partial remainder

    logic [width-1:0]     abs_a, abs_b;
    logic [width:0]       mul_sum;
    logic [width:0]       div_shift, div_diff;
    logic [2*width-1:0]   prod;
    logic [width-1:0]     quo, rmd;

    // Operand magnitudes, one datapath step, and the sign fix-up results.
    always_comb begin
        abs_a     = (!op[0] && A[width-1]) ? -A : A;
        abs_b     = (!op[0] && B[width-1]) ? -B : B;
        mul_sum   = {1'b0, acc_q[2*width-1:width]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q, acc_q[width-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        prod      = neg_q ? -acc_q : acc_q;
        quo       = neg_q ? -acc_q[width-1:0] : acc_q[width-1:0];
        rmd       = rneg_q ? -rem_q : rem_q;
    end

    // Control FSM with HI/LO, busy and done as registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            a_raw_q  <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle && flush) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start && !flush) begin
                            if (!op[2]) begin
                                state_q  <= StCalc;
                                busy_q   <= 1'b1;
                                cnt_q    <= CntW'(width - 1);
                                is_div_q <= op[1];
                                neg_q    <= (A[width-1] ^ B[width-1]) & ~op[0];
                                rneg_q   <= A[width-1] & ~op[0];
                                a_raw_q  <= A;
                                rem_q    <= '0;
                                acc_q    <= {{width{1'b0}}, (op[1] ? abs_a : abs_b)};
                                opnd_q   <= op[1] ? abs_b : abs_a;
                            end else if (!op[1]) begin
                                if (op[0]) lo_q <= A;
                                else       hi_q <= A;
                            end
                        end
                    end
                    StCalc: begin
                        if (is_div_q) begin
                            // Restoring step: keep the difference only if it stayed non-negative.
                            acc_q[width-1:0] <= {acc_q[width-2:0], ~div_diff[width]};
                            rem_q <= div_diff[width] ? div_shift[width-1:0]
                                                     : div_diff[width-1:0];
                        end else begin
                            acc_q <= {mul_sum, acc_q[width-1:1]};
                        end
                        if (cnt_q == '0) state_q <= StFix;
                        else             cnt_q   <= cnt_q - CntW'(1);
                    end
                    StFix: begin
                        if (is_div_q) begin
                            if (opnd_q == '0) begin
                                lo_q <= '1;
                                hi_q <= a_raw_q;
                            end else begin
                                lo_q <= quo;
                                hi_q <= rmd;
                            end
                        end else begin
                            {hi_q, lo_q} <= prod;
                        end
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
